// File: rtl/cv32e41s_pmp_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cv32e41s_pmp_arbiter_pkg
//
// Purpose:
//   Shared types and constants for the PMP/PMR checker arbiter. This includes
//   the access-type and privilege-level encodings seen by the checker, the
//   arbiter FSM state type and the registered request record.
//
// Contents:
//   PMP_ARB_NUM_REQ  number of requesters sharing the checker (IF=0, LSU=1)
//   PMP_ARB_ADDR_W   physical address width handled by the checker
//   pmp_req_e        checker access type (EXEC/READ/WRITE)
//   privlvl_t        RISC-V privilege level encoding
//   pmp_arb_state_e  arbiter FSM state
//   pmp_arb_req_t    registered request driven onto the checker
//   pmp_arb_onehot() owner index -> one-hot requester vector
// ----------------------------------------------------------------------------
package cv32e41s_pmp_arbiter_pkg;

  localparam int PMP_ARB_NUM_REQ = 2;
  localparam int PMP_ARB_ADDR_W  = 34;

  typedef enum logic [1:0] {
    PMP_EXEC  = 2'b00,
    PMP_READ  = 2'b01,
    PMP_WRITE = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  typedef enum logic {
    PMP_ARB_IDLE,
    PMP_ARB_CHECK
  } pmp_arb_state_e;

  typedef struct packed {
    logic [PMP_ARB_ADDR_W-1:0] addr;
    pmp_req_e                  req_type;
    privlvl_t                  priv;
    logic                      dbg_region;
    logic                      owner;
  } pmp_arb_req_t;

  // Converts the registered owner index into the per-requester pulse vector.
  function automatic logic [PMP_ARB_NUM_REQ-1:0] pmp_arb_onehot(input logic owner);
    logic [PMP_ARB_NUM_REQ-1:0] vec;
    vec        = '0;
    vec[owner] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/cv32e41s_pmp_arb_rr.sv
// ----------------------------------------------------------------------------
// cv32e41s_pmp_arb_rr
//
// Purpose:
//   Two-way round-robin picker. A lone valid requester always wins; when both
//   are valid the requester that did not win last time is selected.
//
// Ports:
//   valid_i    in   2  request valid per requester
//   rr_last_i  in   1  index of the requester granted most recently
//   gnt_o      out  2  one-hot grant (all zero when nothing is valid)
// ----------------------------------------------------------------------------
module cv32e41s_pmp_arb_rr
  import cv32e41s_pmp_arbiter_pkg::*;
(
  input  logic [PMP_ARB_NUM_REQ-1:0] valid_i,
  input  logic                       rr_last_i,
  output logic [PMP_ARB_NUM_REQ-1:0] gnt_o
);

  // On a tie, hand the grant to the requester that was not served last.
  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
      gnt_o = rr_last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cv32e41s_pmp_arbiter.sv
// ----------------------------------------------------------------------------
// cv32e41s_pmp_arbiter
//
// Purpose:
//   Shares one combinational PMP/PMR checker between the IF stage (req 0,
//   execute accesses) and the LSU (req 1, read/write accesses). A request is
//   granted in IDLE, registered, presented to the checker for one cycle in
//   CHECK, and the checker result is returned as a one-cycle response pulse
//   to the owning requester. Accept in cycle N gives a response in N+2.
//
// Parameters:
//   RESET_PRIO   requester winning the first tie after reset (0=IF, 1=LSU)
//   FAULT_CNT_W  width of each per-requester fault counter
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid_i[2]      request valid per requester
//   req_ready_o[2]      request accepted (at most one bit set)
//   req_addr_i[2][34]   request address
//   req_type_i[2][2]    access type (pmp_req_e)
//   req_priv_i[2][2]    privilege level (privlvl_t)
//   req_dbg_region_i[2] access targets the Debug Module region
//   resp_valid_o[2]     one-cycle response pulse to the owner
//   resp_err_o          fault flag of the pulsing response (held otherwise)
//   resp_addr_o[34]     relocated address of the pulsing response (held)
//   flush_i             discard the in-flight check
//   csr_pmp_upd_i       PMP/PMR CSRs written this cycle; re-check next cycle
//   chk_*_o             request fields driven to the checker (0 in IDLE)
//   chk_err_i           checker fault result
//   chk_reloc_addr_i    checker relocated address
//   fault_cnt_o[2][W]   saturating per-requester fault count
//
// Configuration:
//   CV32E41S_PMP_ARB_FAULT_CNT_EN  when defined, fault_cnt_o counts faulting
//                                  responses per requester; otherwise it is
//                                  tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module cv32e41s_pmp_arbiter
  import cv32e41s_pmp_arbiter_pkg::*;
#(
  parameter int RESET_PRIO  = 0,
  parameter int FAULT_CNT_W = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [PMP_ARB_NUM_REQ-1:0]                        req_valid_i,
  output logic [PMP_ARB_NUM_REQ-1:0]                        req_ready_o,
  input  logic [PMP_ARB_NUM_REQ-1:0][PMP_ARB_ADDR_W-1:0]    req_addr_i,
  input  logic [PMP_ARB_NUM_REQ-1:0][1:0]                   req_type_i,
  input  logic [PMP_ARB_NUM_REQ-1:0][1:0]                   req_priv_i,
  input  logic [PMP_ARB_NUM_REQ-1:0]                        req_dbg_region_i,
  output logic [PMP_ARB_NUM_REQ-1:0]                        resp_valid_o,
  output logic                                              resp_err_o,
  output logic [PMP_ARB_ADDR_W-1:0]                         resp_addr_o,
  input  logic                                              flush_i,
  input  logic                                              csr_pmp_upd_i,
  output logic [PMP_ARB_ADDR_W-1:0]                         chk_addr_o,
  output logic [1:0]                                        chk_type_o,
  output logic [1:0]                                        chk_priv_o,
  output logic                                              chk_dbg_region_o,
  input  logic                                              chk_err_i,
  input  logic [PMP_ARB_ADDR_W-1:0]                         chk_reloc_addr_i,
  output logic [PMP_ARB_NUM_REQ-1:0][FAULT_CNT_W-1:0]       fault_cnt_o
);

  // rr_last starts on the requester that should lose the first tie.
  localparam logic RR_LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  pmp_arb_state_e                state_q, state_d;
  logic                          rr_last_q, rr_last_d;
  pmp_arb_req_t                  req_q, req_d;
  logic [PMP_ARB_NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic                          resp_err_q, resp_err_d;
  logic [PMP_ARB_ADDR_W-1:0]     resp_addr_q, resp_addr_d;

  logic [PMP_ARB_NUM_REQ-1:0]    gnt;
  logic                          gnt_owner;

  cv32e41s_pmp_arb_rr u_rr (
    .valid_i   (req_valid_i),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt)
  );

  // The grant is one-hot, so its upper bit is the winning requester index.
  assign gnt_owner = gnt[1];

  // Next-state and output logic. In IDLE the grant is combinational so the
  // requester sees ready in the accepting cycle. In CHECK flush beats a CSR
  // update, and a CSR update holds the check for one more cycle so the
  // result reflects the newly written PMP/PMR configuration.
  always_comb begin
    state_d          = state_q;
    rr_last_d        = rr_last_q;
    req_d            = req_q;
    resp_valid_d     = '0;
    resp_err_d       = resp_err_q;
    resp_addr_d      = resp_addr_q;
    req_ready_o      = '0;
    chk_addr_o       = '0;
    chk_type_o       = '0;
    chk_priv_o       = '0;
    chk_dbg_region_o = 1'b0;

    case (state_q)
      PMP_ARB_IDLE: begin
        if (|req_valid_i) begin
          req_ready_o      = gnt;
          req_d.addr       = req_addr_i[gnt_owner];
          req_d.req_type   = pmp_req_e'(req_type_i[gnt_owner]);
          req_d.priv       = privlvl_t'(req_priv_i[gnt_owner]);
          req_d.dbg_region = req_dbg_region_i[gnt_owner];
          req_d.owner      = gnt_owner;
          rr_last_d        = gnt_owner;
          state_d          = PMP_ARB_CHECK;
        end
      end

      PMP_ARB_CHECK: begin
        chk_addr_o       = req_q.addr;
        chk_type_o       = req_q.req_type;
        chk_priv_o       = req_q.priv;
        chk_dbg_region_o = req_q.dbg_region;
        if (flush_i) begin
          state_d = PMP_ARB_IDLE;
        end else if (!csr_pmp_upd_i) begin
          resp_valid_d = pmp_arb_onehot(req_q.owner);
          resp_err_d   = chk_err_i;
          resp_addr_d  = chk_reloc_addr_i;
          state_d      = PMP_ARB_IDLE;
        end
      end

      default: begin
        state_d = PMP_ARB_IDLE;
      end
    endcase
  end

  // State, round-robin pointer, request register and response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PMP_ARB_IDLE;
      rr_last_q    <= RR_LAST_RST;
      req_q        <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_addr_q  <= resp_addr_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_addr_o  = resp_addr_q;

`ifdef CV32E41S_PMP_ARB_FAULT_CNT_EN
  logic [PMP_ARB_NUM_REQ-1:0][FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  // Count faulting responses per owner; counters stick at all-ones. Flushed
  // checks never pulse a response and so are never counted.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    for (int r = 0; r < PMP_ARB_NUM_REQ; r++) begin
      if (resp_valid_q[r] && resp_err_q && (fault_cnt_q[r] != '1)) begin
        fault_cnt_d[r] = fault_cnt_q[r] + FAULT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fault_cnt_o = fault_cnt_q;
`else
  assign fault_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e41s_pmp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cv32e41s_pmp_arbiter
//
// Self-checking bench for cv32e41s_pmp_arbiter. A small behavioural checker
// model answers the chk_* interface: execute outside [0x1000,0x2000) faults,
// write at or above 0x8000 faults, debug-region accesses never fault, and
// U-mode addresses are relocated by a PMR offset whose new value becomes
// visible one cycle after it is written. Expected responses are queued when
// a request is accepted and compared when the response pulse arrives.
// ----------------------------------------------------------------------------
module tb_cv32e41s_pmp_arbiter;
  import cv32e41s_pmp_arbiter_pkg::*;

  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [1:0][33:0]  req_addr_i;
  logic [1:0][1:0]   req_type_i;
  logic [1:0][1:0]   req_priv_i;
  logic [1:0]        req_dbg_region_i;
  logic [1:0]        resp_valid_o;
  logic              resp_err_o;
  logic [33:0]       resp_addr_o;
  logic              flush_i;
  logic              csr_pmp_upd_i;
  logic [33:0]       chk_addr_o;
  logic [1:0]        chk_type_o;
  logic [1:0]        chk_priv_o;
  logic              chk_dbg_region_o;
  logic              chk_err_i;
  logic [33:0]       chk_reloc_addr_i;
  logic [1:0][CW-1:0] fault_cnt_o;

  logic [33:0]       pmr_off_set;
  logic [33:0]       pmr_off_q;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [33:0] addr;
    int          due;
  } exp_t;

  typedef struct packed {
    logic [1:0]  valid;
    logic [33:0] addr0;
    logic [1:0]  type0;
    logic [1:0]  priv0;
    logic [33:0] addr1;
    logic [1:0]  type1;
    logic [1:0]  priv1;
    logic [1:0]  dbg;
    logic [1:0]  exp_gnt;
    logic        exp_err;
    logic [33:0] exp_addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  cv32e41s_pmp_arbiter #(
    .RESET_PRIO  (0),
    .FAULT_CNT_W (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_type_i       (req_type_i),
    .req_priv_i       (req_priv_i),
    .req_dbg_region_i (req_dbg_region_i),
    .resp_valid_o     (resp_valid_o),
    .resp_err_o       (resp_err_o),
    .resp_addr_o      (resp_addr_o),
    .flush_i          (flush_i),
    .csr_pmp_upd_i    (csr_pmp_upd_i),
    .chk_addr_o       (chk_addr_o),
    .chk_type_o       (chk_type_o),
    .chk_priv_o       (chk_priv_o),
    .chk_dbg_region_o (chk_dbg_region_o),
    .chk_err_i        (chk_err_i),
    .chk_reloc_addr_i (chk_reloc_addr_i),
    .fault_cnt_o      (fault_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    pmr_off_q <= pmr_off_set;
  end

  // Behavioural PMP/PMR checker model.
  always_comb begin
    chk_err_i = 1'b0;
    if (!chk_dbg_region_o) begin
      if (chk_type_o == PMP_EXEC && (chk_addr_o < 34'h1000 || chk_addr_o >= 34'h2000)) chk_err_i = 1'b1;
      if (chk_type_o == PMP_WRITE && chk_addr_o >= 34'h8000) chk_err_i = 1'b1;
    end
    chk_reloc_addr_i = (chk_priv_o == PRIV_LVL_U) ? chk_addr_o + pmr_off_q : chk_addr_o;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got nothing, expected event (cycle %0d)", name, cyc);
  endtask

  task automatic apply_stimulus(input logic [1:0] valid,
                                input logic [33:0] a0, input logic [1:0] t0, input logic [1:0] p0,
                                input logic [33:0] a1, input logic [1:0] t1, input logic [1:0] p1,
                                input logic [1:0] dbg);
    req_valid_i      = valid;
    req_addr_i[0]    = a0;
    req_type_i[0]    = t0;
    req_priv_i[0]    = p0;
    req_addr_i[1]    = a1;
    req_type_i[1]    = t1;
    req_priv_i[1]    = p1;
    req_dbg_region_i = dbg;
  endtask

  function automatic vec_t mk(input logic [1:0] valid,
                              input logic [33:0] a0, input logic [1:0] t0, input logic [1:0] p0,
                              input logic [33:0] a1, input logic [1:0] t1, input logic [1:0] p1,
                              input logic [1:0] dbg, input logic [1:0] gnt, input logic err,
                              input logic [33:0] addr);
    vec_t v;
    v.valid = valid; v.addr0 = a0; v.type0 = t0; v.priv0 = p0;
    v.addr1 = a1; v.type1 = t1; v.priv1 = p1; v.dbg = dbg;
    v.exp_gnt = gnt; v.exp_err = err; v.exp_addr = addr;
    return v;
  endfunction

  task automatic wait_accept(output logic [1:0] gnt, output int at);
    bit seen;
    seen = 1'b0;
    gnt  = 2'b00;
    at   = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00) begin
        seen = 1'b1;
        gnt  = req_ready_o;
        at   = cyc;
      end
    end
    if (!seen) fail_now("accept_timeout");
  endtask

  task automatic push_exp(input logic owner, input logic err, input logic [33:0] addr, input int due);
    exp_t e;
    e.owner = owner;
    e.err   = err;
    e.addr  = addr;
    e.due   = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  initial begin
    logic [1:0] g;
    int         at;
    int         at2;
    int         prev;
    exp_t       ex;
    logic [CW-1:0] exp_sat;

    vecs[0] = mk(2'b01, 34'h1000, PMP_EXEC,  PRIV_LVL_M, 34'h0,    PMP_READ,  PRIV_LVL_M, 2'b00, 2'b01, 1'b0, 34'h1000);
    vecs[1] = mk(2'b10, 34'h0,    PMP_EXEC,  PRIV_LVL_M, 34'h2000, PMP_WRITE, PRIV_LVL_U, 2'b00, 2'b10, 1'b0, 34'h2100);
    vecs[2] = mk(2'b01, 34'h3000, PMP_EXEC,  PRIV_LVL_M, 34'h0,    PMP_READ,  PRIV_LVL_M, 2'b00, 2'b01, 1'b1, 34'h3000);
    vecs[3] = mk(2'b10, 34'h0,    PMP_EXEC,  PRIV_LVL_M, 34'h9000, PMP_WRITE, PRIV_LVL_M, 2'b00, 2'b10, 1'b1, 34'h9000);
    vecs[4] = mk(2'b10, 34'h0,    PMP_EXEC,  PRIV_LVL_M, 34'h9000, PMP_READ,  PRIV_LVL_U, 2'b00, 2'b10, 1'b0, 34'h9100);
    vecs[5] = mk(2'b11, 34'h1004, PMP_EXEC,  PRIV_LVL_M, 34'h2004, PMP_READ,  PRIV_LVL_U, 2'b00, 2'b01, 1'b0, 34'h1004);
    vecs[6] = mk(2'b11, 34'h1008, PMP_EXEC,  PRIV_LVL_M, 34'h2004, PMP_READ,  PRIV_LVL_U, 2'b00, 2'b10, 1'b0, 34'h2104);
    vecs[7] = mk(2'b01, 34'h3000, PMP_EXEC,  PRIV_LVL_M, 34'h0,    PMP_READ,  PRIV_LVL_M, 2'b01, 2'b01, 1'b0, 34'h3000);

    rst           = 1'b1;
    flush_i       = 1'b0;
    csr_pmp_upd_i = 1'b0;
    pmr_off_set   = 34'h100;
    apply_stimulus(2'b00, 34'h0, 2'b00, 2'b00, 34'h0, 2'b00, 2'b00, 2'b00);

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            if (resp_valid_o != 2'b00) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got resp_valid 0x%0h, expected none (cycle %0d)", resp_valid_o, cyc);
              end else begin
                e = sb.pop_front();
                check_output("resp_valid", 64'(resp_valid_o), e.owner ? 64'h2 : 64'h1);
                check_output("resp_err",   64'(resp_err_o),   64'(e.err));
                check_output("resp_addr",  64'(resp_addr_o),  64'(e.addr));
                check_output("resp_cycle", 64'(cyc),          64'(e.due));
              end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
              e = sb.pop_front();
              fail_now("missing_resp");
            end
          end
        end
      end
    join_none

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ready",      64'(req_ready_o),      64'h0);
    check_output("rst_resp_valid", 64'(resp_valid_o),     64'h0);
    check_output("rst_resp_err",   64'(resp_err_o),       64'h0);
    check_output("rst_resp_addr",  64'(resp_addr_o),      64'h0);
    check_output("rst_chk_addr",   64'(chk_addr_o),       64'h0);
    check_output("rst_chk_type",   64'({chk_type_o, chk_priv_o, chk_dbg_region_o}), 64'h0);
    check_output("rst_fault_cnt",  64'(fault_cnt_o),      64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Both requesters valid every cycle: IF, LSU, IF, LSU, one per 2 cycles.
    apply_stimulus(2'b11, 34'h1000, PMP_EXEC, PRIV_LVL_M, 34'h2000, PMP_WRITE, PRIV_LVL_U, 2'b00);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(g, at);
      check_output($sformatf("rr_order%0d", i), 64'(g), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0) check_output($sformatf("rr_spacing%0d", i), 64'(at - prev), 64'd2);
      prev = at;
      if (g == 2'b10) push_exp(1'b1, 1'b0, 34'h2100, at + 2);
      else            push_exp(1'b0, 1'b0, 34'h1000, at + 2);
      @(posedge clk);
    end
    #1 req_valid_i = 2'b00;
    drain();

    // Table-driven single transactions.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      apply_stimulus(vecs[i].valid, vecs[i].addr0, vecs[i].type0, vecs[i].priv0,
                     vecs[i].addr1, vecs[i].type1, vecs[i].priv1, vecs[i].dbg);
      wait_accept(g, at);
      check_output($sformatf("vec%0d_gnt", i), 64'(g), 64'(vecs[i].exp_gnt));
      push_exp(vecs[i].exp_gnt[1], vecs[i].exp_err, vecs[i].exp_addr, at + 2);
      @(posedge clk);
      #1 req_valid_i = 2'b00;
    end
    drain();

    // Flush in CHECK (with a simultaneous CSR update): no response, and a
    // waiting LSU request is granted in the following cycle.
    @(posedge clk);
    #1;
    apply_stimulus(2'b01, 34'h1000, PMP_EXEC, PRIV_LVL_M, 34'h0, PMP_READ, PRIV_LVL_M, 2'b00);
    wait_accept(g, at);
    @(posedge clk);
    #1;
    flush_i       = 1'b1;
    csr_pmp_upd_i = 1'b1;
    apply_stimulus(2'b10, 34'h0, PMP_EXEC, PRIV_LVL_M, 34'h2000, PMP_WRITE, PRIV_LVL_U, 2'b00);
    @(posedge clk);
    #1;
    flush_i       = 1'b0;
    csr_pmp_upd_i = 1'b0;
    wait_accept(g, at2);
    check_output("flush_next_gnt",   64'(g),         64'h2);
    check_output("flush_next_cycle", 64'(at2 - at),  64'd2);
    push_exp(1'b1, 1'b0, 34'h2100, at2 + 2);
    @(posedge clk);
    #1 req_valid_i = 2'b00;
    drain();

    // CSR update in CHECK: response one cycle later, using the new offset.
    @(posedge clk);
    #1;
    apply_stimulus(2'b10, 34'h0, PMP_EXEC, PRIV_LVL_M, 34'h2000, PMP_WRITE, PRIV_LVL_U, 2'b00);
    wait_accept(g, at);
    check_output("csr_gnt", 64'(g), 64'h2);
    @(posedge clk);
    #1;
    req_valid_i   = 2'b00;
    csr_pmp_upd_i = 1'b1;
    pmr_off_set   = 34'h200;
    @(posedge clk);
    #1;
    csr_pmp_upd_i = 1'b0;
    ex.owner = 1'b1;
    ex.err   = 1'b0;
    ex.addr  = 34'h2200;
    ex.due   = at + 3;
    sb.push_back(ex);
    drain();
    pmr_off_set = 34'h100;
    repeat (2) @(posedge clk);

    // Reset while a check is in flight: outputs clear, no response follows,
    // and the first tie afterwards goes to IF.
    #1;
    apply_stimulus(2'b01, 34'h1000, PMP_EXEC, PRIV_LVL_M, 34'h0, PMP_READ, PRIV_LVL_M, 2'b00);
    wait_accept(g, at);
    @(posedge clk);
    #1;
    req_valid_i = 2'b00;
    rst         = 1'b1;
    #1;
    check_output("midrst_resp_valid", 64'(resp_valid_o), 64'h0);
    check_output("midrst_chk_addr",   64'(chk_addr_o),   64'h0);
    check_output("midrst_resp_addr",  64'(resp_addr_o),  64'h0);
    check_output("midrst_fault_cnt",  64'(fault_cnt_o),  64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    apply_stimulus(2'b11, 34'h1000, PMP_EXEC, PRIV_LVL_M, 34'h2000, PMP_WRITE, PRIV_LVL_U, 2'b00);
    wait_accept(g, at);
    check_output("postrst_tie_gnt", 64'(g), 64'h1);
    push_exp(1'b0, 1'b0, 34'h1000, at + 2);
    @(posedge clk);
    #1 req_valid_i = 2'b00;
    drain();

    // Five LSU faults.
`ifdef CV32E41S_PMP_ARB_FAULT_CNT_EN
    exp_sat = '1;
`else
    exp_sat = '0;
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      apply_stimulus(2'b10, 34'h0, PMP_EXEC, PRIV_LVL_M, 34'h9000, PMP_WRITE, PRIV_LVL_M, 2'b00);
      wait_accept(g, at);
      push_exp(1'b1, 1'b1, 34'h9000, at + 2);
      @(posedge clk);
      #1 req_valid_i = 2'b00;
    end
    drain();
    repeat (2) @(negedge clk);
    check_output("fault_cnt_lsu", 64'(fault_cnt_o[1]), 64'(exp_sat));
    check_output("fault_cnt_if",  64'(fault_cnt_o[0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
